// File: rtl/uart_tx_cfg_if.sv
// AXI4-Stream style word handshake feeding the UART transmitter.
//   tdata  : word to send, LSB goes on the line first
//   tvalid : source has a word
//   tready : transmitter can accept a word
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with an input FIFO.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   s_axis        : word stream in (slave side of uart_tx_cfg_if)
//   prescale      : bit period = 8*prescale clocks, 0 acts as 1
//   data_bits     : data bits per frame, clamped to 5..DATA_WIDTH
//   parity_mode   : 00 none, 01 even, 10 odd, 11 mark
//   stop_bits     : 0 one stop bit, 1 two stop bits
//   txd           : serial line, idle high
//   busy          : a frame is on the line
//   fifo_count    : words waiting, excluding the one being sent
module uart_tx_cfg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_cfg_if.slave                  s_axis,
    input  logic [15:0]                   prescale,
    input  logic [3:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 19;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [3:0]    DW_C    = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  par, par_n;
    logic [3:0]            f_nbits, f_nbits_n;
    logic [1:0]            f_pmode, f_pmode_n;
    logic                  f_stop2, f_stop2_n;
    logic [TW-1:0]         f_period_m1, f_period_m1_n;
    logic                  txd_n, busy_n;
    logic                  tready_q, tready_n;
    logic [CW-1:0]         count_n;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  push, pop, finish, tick;
    logic [15:0]           ps_c;
    logic [TW-1:0]         period_m1_c;
    logic [3:0]            nbits_c;

    assign s_axis.tready = tready_q;
    assign push          = s_axis.tvalid && tready_q;
    assign tick          = (timer == '0);

    // Sanitised frame parameters, sampled only when a word is popped
    assign ps_c        = (prescale == 16'd0) ? 16'd1 : prescale;
    assign period_m1_c = {ps_c, 3'b000} - 19'd1;
    assign nbits_c     = (data_bits < 4'd5) ? 4'd5 : ((data_bits > DW_C) ? DW_C : data_bits);

    // Engine next-state, line level and pop decision
    always_comb begin
        state_n       = state;
        timer_n       = timer;
        bit_cnt_n     = bit_cnt;
        shreg_n       = shreg;
        par_n         = par;
        f_nbits_n     = f_nbits;
        f_pmode_n     = f_pmode;
        f_stop2_n     = f_stop2;
        f_period_m1_n = f_period_m1;
        txd_n         = txd;
        busy_n        = busy;
        pop           = 1'b0;
        finish        = 1'b0;

        if (state != IDLE && !tick) timer_n = timer - 19'd1;

        case (state)
            IDLE: begin
                if (fifo_count != '0) pop = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    timer_n   = f_period_m1;
                    txd_n     = shreg[0];
                    par_n     = par ^ shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = 4'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_n = f_period_m1;
                    // par already covers exactly the bits sent so far
                    if (bit_cnt == f_nbits) begin
                        if (f_pmode == 2'b00) begin
                            state_n = STOP1;
                            txd_n   = 1'b1;
                        end else begin
                            state_n = PARITY;
                            case (f_pmode)
                                2'b01:   txd_n = par;
                                2'b10:   txd_n = ~par;
                                default: txd_n = 1'b1;
                            endcase
                        end
                    end else begin
                        txd_n     = shreg[0];
                        par_n     = par ^ shreg[0];
                        shreg_n   = shreg >> 1;
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n = STOP1;
                    timer_n = f_period_m1;
                    txd_n   = 1'b1;
                end
            end
            STOP1: begin
                if (tick) begin
                    if (f_stop2) begin
                        state_n = STOP2;
                        timer_n = f_period_m1;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (tick) finish = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // End of frame: chain straight into the next START when a word waits
        if (finish) begin
            if (fifo_count != '0) begin
                pop = 1'b1;
            end else begin
                state_n = IDLE;
                busy_n  = 1'b0;
                txd_n   = 1'b1;
            end
        end

        if (pop) begin
            state_n       = START;
            shreg_n       = mem[rd_ptr];
            f_nbits_n     = nbits_c;
            f_pmode_n     = parity_mode;
            f_stop2_n     = stop_bits;
            f_period_m1_n = period_m1_c;
            timer_n       = period_m1_c;
            bit_cnt_n     = 4'd0;
            par_n         = 1'b0;
            txd_n         = 1'b0;
            busy_n        = 1'b1;
        end
    end

    assign count_n  = fifo_count + CW'(push) - CW'(pop);
    assign tready_n = (count_n < DEPTH_C);

    // State, datapath and FIFO bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            f_nbits     <= 4'd5;
            f_pmode     <= 2'b00;
            f_stop2     <= 1'b0;
            f_period_m1 <= '0;
            txd         <= 1'b1;
            busy        <= 1'b0;
            tready_q    <= 1'b0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            par         <= par_n;
            f_nbits     <= f_nbits_n;
            f_pmode     <= f_pmode_n;
            f_stop2     <= f_stop2_n;
            f_period_m1 <= f_period_m1_n;
            txd         <= txd_n;
            busy        <= busy_n;
            tready_q    <= tready_n;
            fifo_count  <= count_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // FIFO storage; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_axis.tdata;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a word-queue / waveform-list model
// predicts txd, busy, fifo_count and tready every clock.
module tb_uart_tx_cfg;
    localparam int unsigned DW    = 9;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] prescale = 16'd1;
    logic [3:0]  data_bits = 4'd8;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop_bits = 1'b0;
    logic        txd, busy;
    logic [2:0]  fifo_count;

    uart_tx_cfg_if #(.DATA_WIDTH(DW)) s_axis ();

    uart_tx_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_axis),
        .prescale    (prescale),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .txd         (txd),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int nassert = 0;
    int nfail   = 0;

    logic [DW-1:0] src_q[$];   // words the source still has to offer
    logic [DW-1:0] pw[$];      // words accepted but not yet on the line
    bit            exp_q[$];   // expected txd level, one entry per clock
    bit            hs_pending = 1'b0;
    int            busy_cycles = 0;
    int            acc_cnt = 0;
    int            first_low_acc = -1;
    int            peak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line waveform for one word under the current configuration
    function automatic void gen_frame(input logic [DW-1:0] w);
        int n, t, ones;
        bit bits[$];
        n = (data_bits < 5) ? 5 : ((data_bits > DW) ? DW : int'(data_bits));
        t = 8 * ((prescale == 0) ? 1 : int'(prescale));
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        case (parity_mode)
            2'b01: bits.push_back(bit'(ones % 2));
            2'b10: bits.push_back(bit'(1 - ones % 2));
            2'b11: bits.push_back(1'b1);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (stop_bits) bits.push_back(1'b1);
        foreach (bits[k]) repeat (t) exp_q.push_back(bits[k]);
    endfunction

    // One clock: check outputs, account handshake, advance model, drive source
    task automatic cycle();
        bit exp_txd, exp_busy;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_txd  = exp_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_txd  = 1'b1;
            exp_busy = 1'b0;
        end
        chk("txd", txd, 32'(exp_txd));
        chk("busy", busy, 32'(exp_busy));
        if (busy === 1'b1) busy_cycles++;
        if (hs_pending) begin
            pw.push_back(src_q.pop_front());
            acc_cnt++;
        end
        chk("fifo_count", 32'(fifo_count), 32'(pw.size()));
        chk("tready", 32'(s_axis.tready), 32'(pw.size() < DEPTH));
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        if (s_axis.tready === 1'b0 && first_low_acc < 0) first_low_acc = acc_cnt;
        if (exp_q.size() == 0 && pw.size() > 0) gen_frame(pw.pop_front());
        if (src_q.size() > 0) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = src_q[0];
        end else begin
            s_axis.tvalid = 1'b0;
        end
        hs_pending = s_axis.tvalid && s_axis.tready;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(src_q.size() == 0 && pw.size() == 0 && exp_q.size() == 0) && n < budget);
        chk("drain_timeout", 32'(n < budget), 32'd1);
        repeat (3) cycle();
    endtask

    task automatic set_cfg(input int ps, input int nb, input int pm, input int sb);
        prescale    = 16'(ps);
        data_bits   = 4'(nb);
        parity_mode = 2'(pm);
        stop_bits   = 1'(sb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", txd, 32'd1);
        chk("rst_busy", busy, 32'd0);
        chk("rst_tready", s_axis.tready, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_tready_low", s_axis.tready, 32'd0);
        repeat (2) cycle();

        // 8N1 baseline, 0x55
        set_cfg(1, 8, 0, 0);
        busy_cycles = 0;
        src_q.push_back(9'h055);
        run_until_idle(400);
        chk("8n1_busy_len", 32'(busy_cycles), 32'd80);

        // 7E2, 0xC1 (bit7 ignored)
        set_cfg(1, 7, 1, 1);
        busy_cycles = 0;
        src_q.push_back(9'h0C1);
        run_until_idle(400);
        chk("7e2_busy_len", 32'(busy_cycles), 32'd88);

        // 9O1 with all ones, then mark parity
        set_cfg(1, 9, 2, 0);
        busy_cycles = 0;
        src_q.push_back(9'h1FF);
        run_until_idle(400);
        chk("9o1_busy_len", 32'(busy_cycles), 32'd96);
        set_cfg(1, 9, 3, 0);
        busy_cycles = 0;
        src_q.push_back(9'h1FF);
        run_until_idle(400);
        chk("9m1_busy_len", 32'(busy_cycles), 32'd96);

        // Clamping: 3 acts as 5, 15 acts as 9; prescale 0 acts as 1
        set_cfg(0, 3, 0, 0);
        busy_cycles = 0;
        src_q.push_back(9'h1EA);
        run_until_idle(400);
        chk("nb3_busy_len", 32'(busy_cycles), 32'd56);
        set_cfg(1, 15, 1, 0);
        busy_cycles = 0;
        src_q.push_back(9'h133);
        run_until_idle(400);
        chk("nb15_busy_len", 32'(busy_cycles), 32'd96);

        // FIFO burst, prescale 2, six words
        set_cfg(2, 8, 0, 0);
        busy_cycles = 0;
        acc_cnt = 0;
        first_low_acc = -1;
        peak = 0;
        for (int i = 1; i <= 6; i++) src_q.push_back(9'(i));
        run_until_idle(3000);
        chk("burst_accept_cap", 32'(first_low_acc), 32'd5);
        chk("burst_peak", 32'(peak), 32'd4);
        chk("burst_busy_len", 32'(busy_cycles), 32'd960);

        // Config change mid-frame only affects the queued frame
        set_cfg(1, 8, 0, 0);
        busy_cycles = 0;
        src_q.push_back(9'h0A5);
        src_q.push_back(9'h03C);
        repeat (20) cycle();
        parity_mode = 2'b01;
        stop_bits   = 1'b1;
        run_until_idle(600);
        chk("cfgchg_busy_len", 32'(busy_cycles), 32'd176);

        // Randomized frames and configurations
        for (int r = 0; r < 12; r++) begin
            int nw;
            set_cfg(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                    int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
            nw = int'($urandom_range(6, 1));
            for (int i = 0; i < nw; i++) src_q.push_back(9'($urandom));
            run_until_idle(6000);
        end

        // Reset in the middle of a frame with three words queued
        set_cfg(1, 8, 0, 0);
        for (int i = 0; i < 4; i++) src_q.push_back(9'h0F0 + 9'(i));
        repeat (20) cycle();
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        #2;
        chk("midrst_txd", txd, 32'd1);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_tready", s_axis.tready, 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        src_q.delete();
        pw.delete();
        exp_q.delete();
        s_axis.tvalid = 1'b0;
        hs_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("midrel_tready_low", s_axis.tready, 32'd0);
        busy_cycles = 0;
        repeat (200) cycle();
        chk("midrel_no_frame", 32'(busy_cycles), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
